// File: rtl/rr_stream_demux_pkg.sv
// Shared types and helpers for the round-robin stream demultiplexer.
// Contents: mode_e (gather/scatter operating mode), wrap_inc (lane pointer advance).
// No ports; imported by the interface, the lane register and the top level.
package rr_stream_demux_pkg;

  typedef enum logic {
    MODE_GATHER  = 1'b0,
    MODE_SCATTER = 1'b1
  } mode_e;

  // Advance a lane pointer with an explicit wrap so non-power-of-two lane
  // counts never leave the pointer sitting on a lane that does not exist.
  function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned n);
    return (ptr == n - 1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/rr_stream_demux_if.sv
// Stream + status bundle between a narrow source, the demux and its consumers.
// Ports: mode/in_valid/in_data/out_ready driven by the environment (master);
//        in_ready/out_data/out_valid/cur_lane/active_mode driven by the demux (slave).
interface rr_stream_demux_if
  import rr_stream_demux_pkg::*;
#(
  parameter int NUM_OUTS = 8,
  parameter int DATA_W   = 1
);
  localparam int CNT_W = $clog2(NUM_OUTS);

  mode_e                      mode;
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic [NUM_OUTS*DATA_W-1:0] out_data;
  logic [NUM_OUTS-1:0]        out_valid;
  logic [NUM_OUTS-1:0]        out_ready;
  logic [CNT_W-1:0]           cur_lane;
  mode_e                      active_mode;

  modport master (
    output mode, in_valid, in_data, out_ready,
    input  in_ready, out_data, out_valid, cur_lane, active_mode
  );

  modport slave (
    input  mode, in_valid, in_data, out_ready,
    output in_ready, out_data, out_valid, cur_lane, active_mode
  );

endinterface

// File: rtl/rr_demux_lane.sv
// One output lane: a DATA_W holding register plus its full flag.
// Ports: clk, rst (sync, active-high); i_load/i_data capture a beat, i_clear empties;
//        o_data/o_full expose the held beat. Load and clear never coincide.
module rr_demux_lane
  import rr_stream_demux_pkg::*;
#(
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_load,
  input  logic              i_clear,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full
);

  logic [DATA_W-1:0] r_data;
  logic              r_full;

  // Data is left in place on clear; consumers only look at it while full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_data <= i_data;
      r_full <= 1'b1;
    end else if (i_clear) begin
      r_full <= 1'b0;
    end
  end

  assign o_data = r_data;
  assign o_full = r_full;

endmodule

// File: rtl/rr_stream_demux.sv
// Round-robin demux: successive input beats fill NUM_OUTS one-deep lanes in turn.
// Gather mode emits all lanes as one word; scatter mode drains each lane on its own.
// Ports: clk, rst (sync, active-high); bus (slave modport) carries the stream and status.
module rr_stream_demux
  import rr_stream_demux_pkg::*;
#(
  parameter int NUM_OUTS = 8,
  parameter int DATA_W   = 1
) (
  input  logic              clk,
  input  logic              rst,
  rr_stream_demux_if.slave  bus
);

  localparam int CNT_W = $clog2(NUM_OUTS);

  logic [CNT_W-1:0]           r_ptr;
  mode_e                      r_mode;
  logic [NUM_OUTS-1:0]        w_full;
  logic [NUM_OUTS-1:0]        w_load;
  logic [NUM_OUTS-1:0]        w_clear;
  logic [NUM_OUTS*DATA_W-1:0] w_data;
  logic                       w_in_ready;
  logic                       w_accept;
  logic                       w_word_done;
  logic                       w_idle;

  // Ready looks only at the target lane's flag, so out_ready never reaches in_ready.
  assign w_in_ready  = ~w_full[r_ptr];
  assign w_accept    = bus.in_valid & w_in_ready;
  assign w_word_done = &w_full;
  assign w_idle      = (w_full == '0) && (r_ptr == '0);

  // Gather only drains a complete word with every consumer ready at once;
  // scatter drains each full lane whose consumer is ready.
  always_comb begin
    w_clear = '0;
    if (r_mode == MODE_SCATTER) begin
      w_clear = w_full & bus.out_ready;
    end else if (w_word_done && (&bus.out_ready)) begin
      w_clear = '1;
    end
  end

  always_comb begin
    w_load = '0;
    if (w_accept) begin
      w_load[r_ptr] = 1'b1;
    end
  end

  // Mode is only re-sampled when nothing is held and the pointer is home,
  // so a word is never split across two modes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr  <= '0;
      r_mode <= MODE_GATHER;
    end else begin
      if (w_accept) begin
        r_ptr <= CNT_W'(wrap_inc(32'(r_ptr), NUM_OUTS));
      end
      if (w_idle) begin
        r_mode <= bus.mode;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_OUTS; gi++) begin : g_lane
    rr_demux_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_load[gi]),
      .i_clear (w_clear[gi]),
      .i_data  (bus.in_data),
      .o_data  (w_data[gi*DATA_W +: DATA_W]),
      .o_full  (w_full[gi])
    );
  end

  assign bus.out_data    = w_data;
  assign bus.out_valid   = (r_mode == MODE_SCATTER) ? w_full : {NUM_OUTS{w_word_done}};
  assign bus.in_ready    = w_in_ready;
  assign bus.cur_lane    = r_ptr;
  assign bus.active_mode = r_mode;

endmodule

// File: tb/tb_rr_stream_demux.sv
// Bench for rr_stream_demux: a 4-lane gather/scatter instance and a 3-lane instance,
// both checked every cycle against a queue-of-pending-beats reference model.
// No ports; prints one summary line.
module tb_rr_stream_demux;
  import rr_stream_demux_pkg::*;

  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] dat;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rr_stream_demux_if #(.NUM_OUTS(4), .DATA_W(8)) if4 ();
  rr_stream_demux_if #(.NUM_OUTS(3), .DATA_W(8)) if3 ();

  rr_stream_demux #(.NUM_OUTS(4), .DATA_W(8)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
  rr_stream_demux #(.NUM_OUTS(3), .DATA_W(8)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  int          n_chk = 0;
  int          n_err = 0;
  int          sel = 0;      // 0: 4-lane instance, 1: 3-lane instance
  int          m_n = 4;      // lane count of the selected instance
  int          m_cnt = 0;    // beats accepted since reset; next lane = m_cnt % m_n
  bit          m_known = 1'b0;
  bit          m_mode = 1'b0;
  beat_t       m_pend[$];    // beats accepted but not yet drained
  logic [31:0] em [4];       // per-lane history of emitted beats (newest in low byte)

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic bit m_has(input int lane);
    foreach (m_pend[k]) if (int'(m_pend[k].lane) == lane) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] m_dat(input int lane);
    foreach (m_pend[k]) if (int'(m_pend[k].lane) == lane) return m_pend[k].dat;
    return 8'h00;
  endfunction

  function automatic logic [3:0] m_vld();
    logic [3:0] v = '0;
    bit all_full = 1'b1;
    for (int i = 0; i < m_n; i++) if (!m_has(i)) all_full = 1'b0;
    for (int i = 0; i < m_n; i++) v[i] = m_mode ? m_has(i) : all_full;
    return v;
  endfunction

  function automatic bit m_rdy();
    return !m_has(m_cnt % m_n);
  endfunction

  function automatic logic [3:0] d_vld();
    return (sel == 0) ? if4.out_valid : {1'b0, if3.out_valid};
  endfunction

  function automatic logic [31:0] d_dat();
    return (sel == 0) ? if4.out_data : {8'h00, if3.out_data};
  endfunction

  function automatic logic d_rdy();
    return (sel == 0) ? if4.in_ready : if3.in_ready;
  endfunction

  function automatic logic [1:0] d_lane();
    return (sel == 0) ? if4.cur_lane : if3.cur_lane;
  endfunction

  function automatic logic d_mode();
    return (sel == 0) ? (if4.active_mode == MODE_SCATTER) : (if3.active_mode == MODE_SCATTER);
  endfunction

  // One clock: compare the DUT with the model, apply inputs, advance the model.
  task automatic step(input bit r, input bit iv, input logic [7:0] id,
                      input logic [3:0] ordy, input bit md);
    logic [3:0]  ev;
    logic [3:0]  dv;
    logic [3:0]  drn;
    logic [31:0] ed;
    logic [31:0] dd;
    logic [31:0] mk;
    bit          acc;
    bit          all_rdy;
    ev = m_vld();
    if (m_known) begin
      dv = d_vld();
      dd = d_dat();
      ed = '0;
      mk = '0;
      for (int i = 0; i < m_n; i++) begin
        if (ev[i]) ed[i*8 +: 8] = m_dat(i);
        mk[i*8 +: 8] = {8{ev[i]}};
      end
      chk("out_valid", 32'(dv), 32'(ev));
      chk("out_data", dd & mk, ed);
      chk("in_ready", 32'(d_rdy()), 32'(m_rdy()));
      chk("cur_lane", 32'(d_lane()), 32'(m_cnt % m_n));
      chk("lane_range", 32'(int'(d_lane()) < m_n), 32'd1);
      chk("active_mode", 32'(d_mode()), 32'(m_mode));
      for (int i = 0; i < m_n; i++)
        if (dv[i] && ordy[i]) em[i] = {em[i][23:0], dd[i*8 +: 8]};
    end

    rst = r;
    if (sel == 0) begin
      if4.in_valid = iv; if4.in_data = id; if4.out_ready = ordy; if4.mode = mode_e'(md);
      if3.in_valid = 1'b0; if3.in_data = '0; if3.out_ready = '0; if3.mode = MODE_GATHER;
    end else begin
      if3.in_valid = iv; if3.in_data = id; if3.out_ready = ordy[2:0]; if3.mode = mode_e'(md);
      if4.in_valid = 1'b0; if4.in_data = '0; if4.out_ready = '0; if4.mode = MODE_GATHER;
    end

    if (r) begin
      m_pend.delete();
      m_cnt   = 0;
      m_mode  = 1'b0;
      m_known = 1'b1;
    end else begin
      acc = iv && m_rdy();
      all_rdy = 1'b1;
      for (int i = 0; i < m_n; i++) if (!ordy[i]) all_rdy = 1'b0;
      drn = '0;
      for (int i = 0; i < m_n; i++) drn[i] = ev[i] && (m_mode ? ordy[i] : all_rdy);
      if (m_pend.size() == 0 && (m_cnt % m_n) == 0) m_mode = md;
      for (int k = m_pend.size() - 1; k >= 0; k--)
        if (drn[m_pend[k].lane]) m_pend.delete(k);
      if (acc) begin
        m_pend.push_back('{lane: 2'(m_cnt % m_n), dat: id});
        m_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Hold a beat on the input until the model says it is taken (bounded).
  task automatic send(input logic [7:0] d, input logic [3:0] ordy, input bit md);
    int t = 0;
    while (!m_rdy() && t < 50) begin
      step(1'b0, 1'b1, d, ordy, md);
      t++;
    end
    chk("send_timeout", 32'(t < 50), 32'd1);
    step(1'b0, 1'b1, d, ordy, md);
  endtask

  task automatic rand_run(input int cycles);
    bit         md = 1'b0;
    bit         iv;
    logic [3:0] ordy;
    for (int c = 0; c < cycles; c++) begin
      ordy = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      iv   = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 30) == 0) md = ~md;
      step(($urandom_range(0, 150) == 0), iv, 8'($urandom), ordy, md);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with a beat offered the whole time.
    step(1'b1, 1'b1, 8'hAA, 4'hF, 1'b0);
    step(1'b1, 1'b1, 8'hBB, 4'hF, 1'b0);
    chk("rst_vld", 32'(d_vld()), 32'd0);
    chk("rst_dat", d_dat(), 32'd0);
    chk("rst_rdy", 32'(d_rdy()), 32'd1);
    chk("rst_lane", 32'(d_lane()), 32'd0);
    chk("rst_mode", 32'(d_mode()), 32'd0);
    step(1'b0, 1'b0, 8'h00, 4'hF, 1'b0);

    // Gather one word with consumers always ready.
    send(8'h11, 4'hF, 1'b0);
    send(8'h22, 4'hF, 1'b0);
    send(8'h33, 4'hF, 1'b0);
    send(8'h44, 4'hF, 1'b0);
    chk("g_vld", 32'(d_vld()), 32'hF);
    chk("g_dat", d_dat(), 32'h44332211);
    chk("g_rdy_low", 32'(d_rdy()), 32'd0);
    step(1'b0, 1'b0, 8'h00, 4'hF, 1'b0);
    chk("g_rdy_back", 32'(d_rdy()), 32'd1);
    chk("g_vld_gone", 32'(d_vld()), 32'd0);
    chk("g_lane_home", 32'(d_lane()), 32'd0);

    // Gather with one consumer stalled for five cycles.
    send(8'h55, 4'b0111, 1'b0);
    send(8'h66, 4'b0111, 1'b0);
    send(8'h77, 4'b0111, 1'b0);
    send(8'h88, 4'b0111, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_vld", 32'(d_vld()), 32'hF);
      chk("bp_dat", d_dat(), 32'h88776655);
      chk("bp_rdy", 32'(d_rdy()), 32'd0);
      step(1'b0, 1'b1, 8'h99, 4'b0111, 1'b0);
    end
    step(1'b0, 1'b0, 8'h00, 4'hF, 1'b0);
    chk("bp_drained", 32'(d_vld()), 32'd0);
    chk("bp_rdy_back", 32'(d_rdy()), 32'd1);

    // Mode request arrives mid-word and must wait for idle.
    send(8'h01, 4'hF, 1'b0);
    send(8'h02, 4'hF, 1'b0);
    send(8'h03, 4'hF, 1'b1);
    chk("mc_busy", 32'(d_mode()), 32'd0);
    send(8'h04, 4'hF, 1'b1);
    step(1'b0, 1'b0, 8'h00, 4'hF, 1'b1);
    chk("mc_idle", 32'(d_mode()), 32'd0);
    step(1'b0, 1'b0, 8'h00, 4'hF, 1'b1);
    chk("mc_switched", 32'(d_mode()), 32'd1);

    // Reset after three of four gather beats discards them.
    step(1'b1, 1'b0, 8'h00, 4'hF, 1'b0);
    send(8'hB1, 4'hF, 1'b0);
    send(8'hB2, 4'hF, 1'b0);
    send(8'hB3, 4'hF, 1'b0);
    step(1'b1, 1'b0, 8'h00, 4'hF, 1'b0);
    chk("rmw_vld", 32'(d_vld()), 32'd0);
    send(8'hA1, 4'hF, 1'b0);
    send(8'hA2, 4'hF, 1'b0);
    send(8'hA3, 4'hF, 1'b0);
    send(8'hA4, 4'hF, 1'b0);
    chk("rmw_dat", d_dat(), 32'hA4A3A2A1);
    step(1'b0, 1'b0, 8'h00, 4'hF, 1'b0);

    rand_run(400);

    // Switch to the 3-lane instance.
    sel = 1;
    m_n = 3;
    m_known = 1'b0;
    step(1'b1, 1'b0, 8'h00, 4'h0, 1'b0);
    step(1'b1, 1'b0, 8'h00, 4'h0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 4'b0101, 1'b1);
    chk("sc_mode", 32'(d_mode()), 32'd1);
    for (int i = 0; i < 4; i++) em[i] = '0;
    send(8'h01, 4'b0101, 1'b1);
    send(8'h02, 4'b0101, 1'b1);
    send(8'h03, 4'b0101, 1'b1);
    send(8'h04, 4'b0101, 1'b1);
    chk("sc_block_rdy", 32'(d_rdy()), 32'd0);
    chk("sc_block_lane", 32'(d_lane()), 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 8'h05, 4'b0101, 1'b1);
    chk("sc_still_blocked", 32'(d_rdy()), 32'd0);
    send(8'h05, 4'b0111, 1'b1);
    send(8'h06, 4'b0111, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 4'b0111, 1'b1);
    chk("sc_lane0", em[0], 32'h00000104);
    chk("sc_lane1", em[1], 32'h00000205);
    chk("sc_lane2", em[2], 32'h00000306);

    rand_run(400);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
